dmem_responder: RTL



---
 rtl/dmem_responder.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory slave for the CPU load/store port.
// Big-endian byte array with byte/half/word lanes, zero/sign extension and error reporting.
module dmem_responder #(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signext,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(SIZE);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          signext_q, signext_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;

  logic [7:0]    mem [SIZE];

  logic [32:0]   req_nbytes;
  logic [32:0]   req_end;
  logic          req_err;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_data;
  logic          commit;

  // Request legality is judged on the full 32-bit address before truncation.
  always_comb begin
    req_nbytes = 33'd1;
    case (req_size)
      2'b01:   req_nbytes = 33'd2;
      2'b11:   req_nbytes = 33'd4;
      default: req_nbytes = 33'd1;
    endcase
    req_end = {1'b0, req_addr} + req_nbytes;
    req_err = (req_size == 2'b10)
            || (req_size == 2'b01 && req_addr[0])
            || (req_size == 2'b11 && req_addr[1:0] != 2'b00)
            || (req_end > 33'(SIZE));
  end

  assign a0 = addr_q;
  assign a1 = addr_q + AW'(1);
  assign a2 = addr_q + AW'(2);
  assign a3 = addr_q + AW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{signext_q & b0[7]}}, b0};
      2'b01:   load_data = {{16{signext_q & b0[7]}}, b0, b1};
      default: load_data = {b0, b1, b2, b3};
    endcase
  end

  assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signext_d    = signext_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          addr_d    = req_addr[AW-1:0];
          size_d    = req_size;
          signext_d = req_signext;
          wdata_d   = req_wdata;
          err_d     = req_err;
          cnt_d     = 4'(LATENCY - 1);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          resp_err_d   = err_q;
          resp_rdata_d = (err_q || write_q) ? 32'd0 : load_data;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_rdata_d = 32'd0;
          resp_err_d   = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      size_q       <= 2'b00;
      signext_q    <= 1'b0;
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signext_q    <= signext_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage survives reset; a reset on the commit edge discards the store.
  always_ff @(posedge clock) begin
    if (!reset && commit && write_q && !err_q) begin
      case (size_q)
        2'b00: mem[a0] <= wdata_q[7:0];
        2'b01: begin
          mem[a0] <= wdata_q[15:8];
          mem[a1] <= wdata_q[7:0];
        end
        2'b11: begin
          mem[a0] <= wdata_q[31:24];
          mem[a1] <= wdata_q[23:16];
          mem[a2] <= wdata_q[15:8];
          mem[a3] <= wdata_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
